mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MIPS pipeline MEM stage. Sits between EX/MEM and MEM/WB. Drives a request/acknowledge
//  data-memory port and aligns, extends and byte-enables sub-word accesses. Stalls the
//  pipeline while an access is outstanding and presents a result or bubble to MEM/WB every cycle.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max BUSY cycles without memAck before bus error; 0 = never time out
// PORTS
//  clock        in   1   single clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  validIn      in   1   EX/MEM holds a live instruction
//  aluOutIn     in   32  ALU result / effective address
//  writeDataIn  in   32  store data (rt)
//  memReadIn    in   1   load
//  memWriteIn   in   1   store
//  memSizeIn    in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  memSignedIn  in   1   1 = sign-extend sub-word load, 0 = zero-extend
//  regWriteIn   in   1   pass-through control
//  memToRegIn   in   1   pass-through control
//  regDestIn    in   5   pass-through destination register
//  memReq       out  1   memory request, registered
//  memWe        out  1   1 = write, registered
//  memAddr      out  32  word-aligned address {aluOutIn[31:2],2'b00}, registered
//  memWdata     out  32  store data replicated to lanes, registered
//  memBe        out  4   byte enables, registered
//  memRdata     in   32  read data, valid with memAck
//  memAck       in   1   one-cycle access completion
//  aluOut       out  32  to MEM/WB
//  memOut       out  32  aligned and extended load data, to MEM/WB
//  regWrite     out  1   to MEM/WB; 0 = bubble
//  memToReg     out  1   to MEM/WB
//  regDest      out  5   to MEM/WB
//  stall        out  1   freezes PC, IF/ID, ID/EX and EX/MEM
//  misaligned   out  1   address exception, one cycle
//  busError     out  1   timeout exception, one cycle
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, timeout counter 0, load register 0, memReq/memWe/memAddr/
//   memWdata/memBe 0. Combinational outputs stall, regWrite, misaligned, busError forced 0 while reset_n=0.
//   Reset mid-access drops memReq at once. A late memAck after reset is ignored.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: a memOp is validIn & (memReadIn|memWriteIn).
//   - No memOp: zero-latency pass-through; aluOut/memToReg/regDest follow inputs; regWrite = regWriteIn&validIn; stall=0.
//   - Misaligned memOp (word & addr[1:0]!=0, half & addr[0]!=0): misaligned=1, regWrite=0, stall=0, no request, stay IDLE.
//   - Aligned memOp: stall=1, regWrite=0; on the edge, load memReq=1, memWe=memWriteIn,
//     memAddr, memWdata, memBe; go BUSY.
//  BUSY: memReq held, stall=1, regWrite=0, counter increments.
//   - memAck=1: capture the aligned load into the load register, clear memReq, go DONE.
//   - Counter reaches TIMEOUT_CYCLES with no ack: clear memReq, set error flag, go DONE.
//  DONE: stall=0 for one cycle; regWrite=regWriteIn, or 0 if the error flag is set; busError=error flag;
//   memOut=load register; go IDLE and clear the counter and flag. EX/MEM inputs are stable until this edge.
//  Minimum memOp latency: 3 cycles (stall high 2 cycles) with ack in the first BUSY cycle.
//  Loads are little-endian. Byte lane = addr[1:0]; half select = addr[1]. Extend to 32 per memSignedIn.
//   Word loads pass through unchanged.
//  Stores: byte: wdata={4{wd[7:0]}}, be=0001<<addr[1:0]; half: {2{wd[15:0]}}, be=0011<<{addr[1],1'b0}; word: be=1111.
//  memOut equals the load register in all states. Its value is meaningful only when memToReg=1 in DONE.
// TESTING
//  1 No memOp: validIn=1, aluOutIn=0x1234, regWriteIn=1 -> same-cycle aluOut=0x1234, regWrite=1, stall=0, memReq never 1.
//  2 lb signed, addr 0x103, memRdata=0x80FF_FF7F with ack on the 1st BUSY cycle ->
//    stall 2 cycles, memAddr=0x100, memBe=0000 read, then DONE memOut=0xFFFF_FF80, regWrite=1.
//  3 sh, addr 0x22, wd=0xAAAA_BEEF -> memWe=1, memBe=1100, memWdata=0xBEEF_BEEF; ack after 3 cycles -> stall held 4 cycles.
//  4 lw at addr 0x6 -> misaligned=1 for 1 cycle, regWrite=0, stall=0, memReq stays 0.
//  5 lw, no ack, TIMEOUT_CYCLES=4 -> memReq for 4 cycles, then busError=1 and regWrite=0 in DONE, back to IDLE.
//  6 reset_n low during BUSY -> memReq=0 immediately; after release, a late ack does not change memOut.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
interface mem_access_stage_if;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memBe;
  logic [31:0] memRdata;
  logic        memAck;

  modport master (
    output memReq, memWe, memAddr, memWdata, memBe,
    input  memRdata, memAck
  );

  modport slave (
    input  memReq, memWe, memAddr, memWdata, memBe,
    output memRdata, memAck
  );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: drives the data-memory bus, aligns/extends sub-word loads,
// replicates store data into byte lanes and stalls the pipe while an access is open.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        validIn,
  input  logic [31:0] aluOutIn,
  input  logic [31:0] writeDataIn,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic [1:0]  memSizeIn,
  input  logic        memSignedIn,
  input  logic        regWriteIn,
  input  logic        memToRegIn,
  input  logic [4:0]  regDestIn,
  mem_access_stage_if.master mem,
  output logic [31:0] aluOut,
  output logic [31:0] memOut,
  output logic        regWrite,
  output logic        memToReg,
  output logic [4:0]  regDest,
  output logic        stall,
  output logic        misaligned,
  output logic        busError
);

  // Counter is wide enough to hold TIMEOUT_CYCLES; at least one bit when timeout is off.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

  state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic     err_q, err_d;
  logic [31:0] load_q, load_d;
  mem_req_t req_q, req_d;

  logic stall_c, rw_c, mis_c, berr_c;
  logic mem_op, mis_addr, timeout_hit;
  logic [3:0]  st_be;
  logic [31:0] st_wd;
  logic [31:0] ld_val;
  logic [4:0]  bsh, hsh;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign mem_op   = validIn & (memReadIn | memWriteIn);
  // Size 11 is reserved and behaves as a word access.
  assign mis_addr = (memSizeIn[1] & (aluOutIn[1:0] != 2'b00)) |
                    ((memSizeIn == 2'b01) & aluOutIn[0]);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Little-endian lane pick for loads.
  assign bsh  = {aluOutIn[1:0], 3'b000};
  assign hsh  = {aluOutIn[1], 4'b0000};
  assign ld_b = memRdata_b();
  assign ld_h = mem.memRdata[hsh +: 16];

  function automatic logic [7:0] memRdata_b();
    return mem.memRdata[bsh +: 8];
  endfunction

  // Align and sign/zero-extend the returned read data.
  always_comb begin
    ld_val = mem.memRdata;
    if (!memSizeIn[1]) begin
      if (memSizeIn[0]) ld_val = {{16{memSignedIn & ld_h[15]}}, ld_h};
      else              ld_val = {{24{memSignedIn & ld_b[7]}}, ld_b};
    end
  end

  // Replicate store data into every lane; byte enables only for stores.
  always_comb begin
    st_wd = writeDataIn;
    st_be = 4'b0000;
    if (memSizeIn[1]) begin
      st_be = 4'b1111;
    end else if (memSizeIn[0]) begin
      st_wd = {2{writeDataIn[15:0]}};
      st_be = 4'b0011 << {aluOutIn[1], 1'b0};
    end else begin
      st_wd = {4{writeDataIn[7:0]}};
      st_be = 4'b0001 << aluOutIn[1:0];
    end
    if (!memWriteIn) st_be = 4'b0000;
  end

  // Next-state and stage outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    load_d  = load_q;
    req_d   = req_q;
    stall_c = 1'b0;
    rw_c    = 1'b0;
    mis_c   = 1'b0;
    berr_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          rw_c = regWriteIn & validIn;
        end else if (mis_addr) begin
          mis_c = 1'b1;
        end else begin
          stall_c = 1'b1;
          req_d   = '{req: 1'b1, we: memWriteIn, addr: {aluOutIn[31:2], 2'b00},
                      wdata: st_wd, be: st_be};
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (TIMEOUT_CYCLES != 0) cnt_d = cnt_q + CW'(1);
        if (mem.memAck) begin
          load_d    = ld_val;
          req_d.req = 1'b0;
          state_d   = DONE;
        end else if (timeout_hit) begin
          req_d.req = 1'b0;
          err_d     = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        rw_c    = regWriteIn & ~err_q;
        berr_c  = err_q;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, load register and registered bus outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      load_q  <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      load_q  <= load_d;
      req_q   <= req_d;
    end
  end

  assign mem.memReq   = req_q.req;
  assign mem.memWe    = req_q.we;
  assign mem.memAddr  = req_q.addr;
  assign mem.memWdata = req_q.wdata;
  assign mem.memBe    = req_q.be;

  assign aluOut     = aluOutIn;
  assign memToReg   = memToRegIn;
  assign regDest    = regDestIn;
  assign memOut     = load_q;
  assign stall      = reset_n & stall_c;
  assign regWrite   = reset_n & rw_c;
  assign misaligned = reset_n & mis_c;
  assign busError   = reset_n & berr_c;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized + directed bench for mem_access_stage against a transaction-level model.
module tb_mem_access_stage;
  localparam int TO = 4;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        validIn, memReadIn, memWriteIn, memSignedIn, regWriteIn, memToRegIn;
  logic [31:0] aluOutIn, writeDataIn;
  logic [1:0]  memSizeIn;
  logic [4:0]  regDestIn;
  logic [31:0] aluOut, memOut;
  logic        regWrite, memToReg, stall, misaligned, busError;
  logic [4:0]  regDest;

  mem_access_stage_if bus();

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n), .validIn(validIn), .aluOutIn(aluOutIn),
    .writeDataIn(writeDataIn), .memReadIn(memReadIn), .memWriteIn(memWriteIn),
    .memSizeIn(memSizeIn), .memSignedIn(memSignedIn), .regWriteIn(regWriteIn),
    .memToRegIn(memToRegIn), .regDestIn(regDestIn), .mem(bus.master),
    .aluOut(aluOut), .memOut(memOut), .regWrite(regWrite), .memToReg(memToReg),
    .regDest(regDest), .stall(stall), .misaligned(misaligned), .busError(busError)
  );

  typedef struct {
    logic        vld, stall, rw, mis, berr, req, bus_chk, we, wd_chk;
    logic [31:0] addr, wdata, mout;
    logic [3:0]  be;
  } exp_t;

  exp_t ex;
  int checks = 0;
  int failures = 0;
  logic [31:0] model_ld;
  int stall_cnt, req_cnt;
  logic [31:0] cap_addr, cap_wdata, last_alu, last_mout;
  logic [3:0]  cap_be;
  logic        cap_we, last_rw, last_mis, last_berr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Expected load result: pick the lane arithmetically, then extend.
  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sgn,
                                              input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v;
    if (sz[1]) return r;
    if (sz[0]) begin
      v = (r >> (16 * int'(a[1]))) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = (r >> (8 * int'(a[1:0]))) & 32'hFF;
      if (sgn && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz[1]) return 4'hF;
    if (sz[0]) return a[1] ? 4'hC : 4'h3;
    return 4'(1 << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] d);
    if (sz[1]) return d;
    if (sz[0]) return d[15:0] * 32'h0001_0001;
    return d[7:0] * 32'h0101_0101;
  endfunction

  // Single compare process: every cycle with a live expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (ex.vld && reset_n) begin
        chk("stall", stall, ex.stall);
        chk("regWrite", regWrite, ex.rw);
        chk("misaligned", misaligned, ex.mis);
        chk("busError", busError, ex.berr);
        chk("memReq", bus.memReq, ex.req);
        chk("memOut", memOut, ex.mout);
        chk("aluOut", aluOut, aluOutIn);
        chk("memToReg", memToReg, memToRegIn);
        chk("regDest", regDest, regDestIn);
        if (ex.bus_chk) begin
          chk("memAddr", bus.memAddr, ex.addr);
          chk("memBe", bus.memBe, ex.be);
          chk("memWe", bus.memWe, ex.we);
        end
        if (ex.wd_chk) chk("memWdata", bus.memWdata, ex.wdata);
        stall_cnt += int'(stall);
        req_cnt   += int'(bus.memReq);
        if (bus.memReq) begin
          cap_addr = bus.memAddr; cap_be = bus.memBe;
          cap_we = bus.memWe; cap_wdata = bus.memWdata;
        end
        last_alu = aluOut; last_mout = memOut; last_rw = regWrite;
        last_mis = misaligned; last_berr = busError;
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // One EX/MEM instruction held until the stage releases it; lat = BUSY cycle of the ack.
  task automatic run_op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdata, input logic rw, input logic m2r,
                        input logic [4:0] dst, input int lat);
    logic op, mis, to;
    int nb;
    exp_t e;
    op  = v & (rd | wr);
    mis = op & ((sz[1] & (a[1:0] != 2'b00)) | ((sz == 2'b01) & a[0]));
    validIn = v; memReadIn = rd; memWriteIn = wr; memSizeIn = sz; memSignedIn = sgn;
    aluOutIn = a; writeDataIn = wd; regWriteIn = rw; memToRegIn = m2r; regDestIn = dst;
    bus.memAck = 1'b0; bus.memRdata = rdata;
    stall_cnt = 0; req_cnt = 0;
    e = '{default: '0};
    e.vld = 1'b1; e.mout = model_ld;
    if (!op) begin
      e.rw = rw & v; ex = e; cyc();
    end else if (mis) begin
      e.mis = 1'b1; ex = e; cyc();
    end else begin
      e.stall = 1'b1; ex = e; cyc();
      to = (lat > TO);
      nb = to ? TO : lat;
      e.req = 1'b1; e.bus_chk = 1'b1; e.we = wr; e.addr = {a[31:2], 2'b00};
      e.be = wr ? model_be(sz, a) : 4'h0; e.wd_chk = wr; e.wdata = model_wd(sz, wd);
      for (int k = 1; k <= nb; k++) begin
        bus.memAck = (k == lat); ex = e; cyc();
      end
      bus.memAck = 1'b0;
      if (!to) model_ld = model_load(sz, sgn, a, rdata);
      e.req = 1'b0; e.bus_chk = 1'b0; e.wd_chk = 1'b0; e.stall = 1'b0;
      e.rw = rw & ~to; e.berr = to; e.mout = model_ld;
      ex = e; cyc();
    end
  endtask

  initial begin
    ex = '{default: '0};
    model_ld = '0;
    reset_n = 1'b0;
    validIn = 1'b1; memReadIn = 1'b1; memWriteIn = 1'b0; memSizeIn = 2'b10; memSignedIn = 1'b0;
    aluOutIn = 32'h100; writeDataIn = 32'h5555_5555; regWriteIn = 1'b1; memToRegIn = 1'b1;
    regDestIn = 5'd1; bus.memAck = 1'b0; bus.memRdata = 32'h0;
    #2;
    chk("rst_memReq", bus.memReq, 0);   chk("rst_memWe", bus.memWe, 0);
    chk("rst_memAddr", bus.memAddr, 0); chk("rst_memWdata", bus.memWdata, 0);
    chk("rst_memBe", bus.memBe, 0);     chk("rst_stall", stall, 0);
    chk("rst_regWrite", regWrite, 0);   chk("rst_misaligned", misaligned, 0);
    chk("rst_busError", busError, 0);   chk("rst_memOut", memOut, 0);
    cyc(); cyc();
    reset_n = 1'b1;

    // 1: pass-through
    run_op(1, 0, 0, 2'b10, 0, 32'h1234, 0, 0, 1, 0, 5'd3, 1);
    chk("t1_aluOut", last_alu, 32'h1234); chk("t1_regWrite", last_rw, 1);
    chk("t1_stall_cycles", stall_cnt, 0); chk("t1_req_cycles", req_cnt, 0);

    // 2: lb signed at 0x103
    run_op(1, 1, 0, 2'b00, 1, 32'h103, 0, 32'h80FF_FF7F, 1, 1, 5'd4, 1);
    chk("t2_stall_cycles", stall_cnt, 2); chk("t2_memAddr", cap_addr, 32'h100);
    chk("t2_memBe", cap_be, 4'h0);        chk("t2_memOut", last_mout, 32'hFFFF_FF80);
    chk("t2_regWrite", last_rw, 1);

    // 3: sh at 0x22, ack on third BUSY cycle
    run_op(1, 0, 1, 2'b01, 0, 32'h22, 32'hAAAA_BEEF, 32'h0, 0, 0, 5'd0, 3);
    chk("t3_memWe", cap_we, 1);          chk("t3_memBe", cap_be, 4'hC);
    chk("t3_memWdata", cap_wdata, 32'hBEEF_BEEF); chk("t3_stall_cycles", stall_cnt, 4);

    // 4: misaligned lw at 0x6
    run_op(1, 1, 0, 2'b10, 0, 32'h6, 0, 0, 1, 1, 5'd5, 1);
    chk("t4_misaligned", last_mis, 1); chk("t4_regWrite", last_rw, 0);
    chk("t4_stall_cycles", stall_cnt, 0); chk("t4_req_cycles", req_cnt, 0);

    // 5: lw with no ack -> timeout
    run_op(1, 1, 0, 2'b10, 0, 32'h40, 0, 32'h1111_2222, 1, 1, 5'd6, 99);
    chk("t5_req_cycles", req_cnt, TO); chk("t5_busError", last_berr, 1);
    chk("t5_regWrite", last_rw, 0);
    run_op(0, 0, 0, 2'b10, 0, 32'h0, 0, 0, 1, 0, 5'd0, 1);
    chk("t5_idle_after", stall_cnt, 0);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      int kind;
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      kind = $urandom_range(0, 2);
      run_op(($urandom_range(0, 7) != 0), kind == 1, kind == 2, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, $urandom, $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom_range(1, 6));
    end

    // 6: reset during BUSY, then a late ack
    run_op(1, 1, 0, 2'b10, 0, 32'h80, 0, 32'hCAFE_F00D, 1, 1, 5'd7, 1);
    validIn = 1'b1; memReadIn = 1'b1; memWriteIn = 1'b0; memSizeIn = 2'b10; aluOutIn = 32'h84;
    bus.memAck = 1'b0;
    ex = '{default: '0}; ex.vld = 1'b1; ex.stall = 1'b1; ex.mout = model_ld; cyc();
    ex.req = 1'b1; cyc();
    ex.vld = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t6_memReq_in_reset", bus.memReq, 0); chk("t6_stall_in_reset", stall, 0);
    chk("t6_regWrite_in_reset", regWrite, 0); chk("t6_memOut_in_reset", memOut, 0);
    model_ld = '0;
    cyc(); cyc();
    reset_n = 1'b1;
    validIn = 1'b0; bus.memAck = 1'b1; bus.memRdata = 32'hDEAD_BEEF;
    ex = '{default: '0}; ex.vld = 1'b1; ex.rw = 1'b0; ex.mout = model_ld;
    cyc();
    bus.memAck = 1'b0;
    cyc();
    chk("t6_memOut_after_late_ack", last_mout, 0);
    ex.vld = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
